// File: rtl/apb_timer_slave_if.sv
// ---------------------------------------------------------------------------
// apb_timer_slave_if
//   APB3-style bus bundle between one master and the timer slave.
//   Clock and reset are not part of the bundle; they stay plain module ports.
//
//   PSEL     master -> slave  slave select
//   PENABLE  master -> slave  access-phase indicator
//   PWRITE   master -> slave  1 = write, 0 = read
//   PADDR    master -> slave  byte address (slave decodes [4:2] only)
//   PWDATA   master -> slave  write data
//   PRDATA   slave -> master  read data, zero outside a completing read
//   PREADY   slave -> master  transfer completion
//   PSLVERR  slave -> master  transfer error, meaningful only with PREADY
// ---------------------------------------------------------------------------
interface apb_timer_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_slave.sv
// ---------------------------------------------------------------------------
// apb_timer_slave
//   32-bit down-counting timer behind an APB slave port with a configurable
//   number of wait states per transfer.
//
//   Register map (PADDR[4:2]):
//     0 CTRL   RW  [0] EN, [1] AUTO (reload on expiry), [2] IRQ_EN
//     1 LOAD   RW  reload value; a write also loads VALUE
//     2 VALUE  RO  current count; writes are ignored without error
//     3 STATUS W1C [0] EXP, set when the count expires
//     4..7     unmapped, answered with PSLVERR
//
//   Ports:
//     PCLK     clock, all state changes on the rising edge
//     PRESET   asynchronous active-high reset
//     apb      APB slave modport (see apb_timer_slave_if)
//     irq      level interrupt, EXP & IRQ_EN, driven from flops only
// ---------------------------------------------------------------------------
module apb_timer_slave #(
    parameter int unsigned WAIT_STATES = 0   // PREADY-low access cycles, 0..15
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_timer_slave_if.slave apb,
    output logic             irq
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_LOAD   = 3'd1,
        REG_VALUE  = 3'd2,
        REG_STATUS = 3'd3
    } reg_sel_e;

    // Register state
    logic [3:0]  wait_q,   wait_d;
    logic        en_q,     en_d;
    logic        auto_q,   auto_d;
    logic        irq_en_q, irq_en_d;
    logic        exp_q,    exp_d;
    logic [31:0] load_q,   load_d;
    logic [31:0] value_q,  value_d;

    // Bus decode
    reg_sel_e    reg_sel;
    logic        mapped;
    logic        access;
    logic        ready;
    logic        wr_commit;
    logic        expire;
    logic [31:0] rd_mux;
    logic        unused_paddr;

    assign reg_sel      = reg_sel_e'(apb.PADDR[4:2]);
    assign mapped       = ~apb.PADDR[4];            // indices 4..7 all have bit 4 set
    assign access       = apb.PSEL & apb.PENABLE;
    // Reset gates PREADY directly: with zero wait states the counter alone
    // would otherwise complete an access while PRESET is still high.
    assign ready        = ~PRESET & access & (wait_q == WAIT_LAST);
    assign wr_commit    = ready & apb.PWRITE & mapped;
    assign expire       = en_q & (value_q == 32'd1);
    assign unused_paddr = ^{apb.PADDR[31:5], apb.PADDR[1:0]};

    // Read mux over current register contents
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_CTRL:   rd_mux = {29'd0, irq_en_q, auto_q, en_q};
            REG_LOAD:   rd_mux = load_q;
            REG_VALUE:  rd_mux = value_q;
            REG_STATUS: rd_mux = {31'd0, exp_q};
            default:    rd_mux = '0;
        endcase
    end

    assign apb.PREADY  = ready;
    assign apb.PSLVERR = ready & ~mapped;
    assign apb.PRDATA  = (ready & ~apb.PWRITE & mapped) ? rd_mux : '0;
    assign irq         = exp_q & irq_en_q;

    // Wait counter: counts stalled access cycles; any gap in PSEL/PENABLE or
    // a completed transfer returns it to zero.
    always_comb begin
        wait_d = (access && !ready) ? wait_q + 4'd1 : 4'd0;
    end

    // Timer and register next state. Order matters: the count/expiry update
    // is computed first, then a committing bus write overrides it, which gives
    // LOAD and CTRL writes priority over the expiry side effects.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        en_d     = en_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        exp_d    = exp_q;
        load_d   = load_q;
        value_d  = value_q;

        if (expire) begin
            exp_d = 1'b1;
            if (auto_q) begin
                value_d = load_q;
            end else begin
                value_d = '0;
                en_d    = 1'b0;
            end
        end else if (en_q && value_q != 32'd0) begin
            value_d = value_q - 32'd1;
        end

        if (wr_commit) begin
            case (reg_sel)
                REG_CTRL: {irq_en_d, auto_d, en_d} = apb.PWDATA[2:0];
                REG_LOAD: begin
                    load_d  = apb.PWDATA;
                    value_d = apb.PWDATA;
                end
                // An expiry set in the same cycle beats the clear.
                REG_STATUS: if (apb.PWDATA[0] && !expire) exp_d = 1'b0;
                default: ;  // VALUE is read-only, writes are dropped
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_q   <= '0;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            exp_q    <= 1'b0;
            load_q   <= '0;
            value_q  <= '0;
        end else begin
            wait_q   <= wait_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            irq_en_q <= irq_en_d;
            exp_q    <= exp_d;
            load_q   <= load_d;
            value_q  <= value_d;
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_timer_slave
//   Three timer instances with 0, 3 and 2 wait states, each on its own bus.
//   A per-cycle reference model (one per instance) predicts PREADY, PSLVERR,
//   PRDATA and irq from the register-level behaviour; directed sequences add
//   hand-computed literal expectations for latency, expiry and reset.
// ---------------------------------------------------------------------------
module tb_apb_timer_slave;

    logic pclk;
    logic preset;
    logic irq_ws0, irq_ws3, irq_ws2;

    int checks   = 0;
    int failures = 0;

    apb_timer_slave_if bus_ws0 ();
    apb_timer_slave_if bus_ws3 ();
    apb_timer_slave_if bus_ws2 ();

    apb_timer_slave #(.WAIT_STATES(0)) u_dut_ws0 (
        .PCLK(pclk), .PRESET(preset), .apb(bus_ws0), .irq(irq_ws0));
    apb_timer_slave #(.WAIT_STATES(3)) u_dut_ws3 (
        .PCLK(pclk), .PRESET(preset), .apb(bus_ws3), .irq(irq_ws3));
    apb_timer_slave #(.WAIT_STATES(2)) u_dut_ws2 (
        .PCLK(pclk), .PRESET(preset), .apb(bus_ws2), .irq(irq_ws2));

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- comparison helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b", name, act, req);
        end
    endtask

    // ---------------- per-instance bus access (0: WS0, 1: WS3, 2: WS2) ----------------
    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic drive(input int d, input logic sel, input logic ena, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        case (d)
            0: begin
                bus_ws0.PSEL = sel; bus_ws0.PENABLE = ena; bus_ws0.PWRITE = wr;
                bus_ws0.PADDR = addr; bus_ws0.PWDATA = wdata;
            end
            1: begin
                bus_ws3.PSEL = sel; bus_ws3.PENABLE = ena; bus_ws3.PWRITE = wr;
                bus_ws3.PADDR = addr; bus_ws3.PWDATA = wdata;
            end
            default: begin
                bus_ws2.PSEL = sel; bus_ws2.PENABLE = ena; bus_ws2.PWRITE = wr;
                bus_ws2.PADDR = addr; bus_ws2.PWDATA = wdata;
            end
        endcase
    endtask

    task automatic get_inputs(input int d, output logic sel, output logic ena, output logic wr,
                              output logic [31:0] addr, output logic [31:0] wdata);
        case (d)
            0: begin
                sel = bus_ws0.PSEL; ena = bus_ws0.PENABLE; wr = bus_ws0.PWRITE;
                addr = bus_ws0.PADDR; wdata = bus_ws0.PWDATA;
            end
            1: begin
                sel = bus_ws3.PSEL; ena = bus_ws3.PENABLE; wr = bus_ws3.PWRITE;
                addr = bus_ws3.PADDR; wdata = bus_ws3.PWDATA;
            end
            default: begin
                sel = bus_ws2.PSEL; ena = bus_ws2.PENABLE; wr = bus_ws2.PWRITE;
                addr = bus_ws2.PADDR; wdata = bus_ws2.PWDATA;
            end
        endcase
    endtask

    function automatic logic get_ready(input int d);
        case (d)
            0:       return bus_ws0.PREADY;
            1:       return bus_ws3.PREADY;
            default: return bus_ws2.PREADY;
        endcase
    endfunction

    function automatic logic get_slverr(input int d);
        case (d)
            0:       return bus_ws0.PSLVERR;
            1:       return bus_ws3.PSLVERR;
            default: return bus_ws2.PSLVERR;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        case (d)
            0:       return bus_ws0.PRDATA;
            1:       return bus_ws3.PRDATA;
            default: return bus_ws2.PRDATA;
        endcase
    endfunction

    function automatic logic get_irq(input int d);
        case (d)
            0:       return irq_ws0;
            1:       return irq_ws3;
            default: return irq_ws2;
        endcase
    endfunction

    // One complete APB transfer; returns read data, error flag and the number
    // of access cycles that had PREADY low. Bounded so a stuck slave still
    // reaches the summary.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic slverr, output int waits);
        logic done;
        int   cyc;
        done = 1'b0; rdata = '0; slverr = 1'b0; waits = 0; cyc = 0;
        drive(d, 1'b1, 1'b0, wr, addr, wdata);
        @(posedge pclk); #1;
        drive(d, 1'b1, 1'b1, wr, addr, wdata);
        while (!done && cyc < 40) begin
            @(negedge pclk);
            if (get_ready(d)) begin
                done   = 1'b1;
                rdata  = get_rdata(d);
                slverr = get_slverr(d);
            end else begin
                waits++;
            end
            @(posedge pclk); #1;
            cyc++;
        end
        drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check1($sformatf("d%0d_xfer_completed", d), done, 1'b1);
    endtask

    task automatic apb_write(input int d, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd; logic se; int w;
        apb_xfer(d, 1'b1, addr, data, rd, se, w);
    endtask

    // ---------------- reference model ----------------
    // State visible through the register map, one entry per instance. Updated
    // on the falling edge with the inputs that the next rising edge will see.
    logic        m_en    [3];
    logic        m_auto  [3];
    logic        m_irqen [3];
    logic        m_exp   [3];
    logic [31:0] m_load  [3];
    logic [31:0] m_value [3];
    int          m_acc   [3];

    task automatic model_cycle(input int d);
        logic sel, ena, wr, access, rdy, bad, commit, expiry, nen, nexp;
        logic [31:0] addr, wdata, rd_val, nval;
        logic [2:0]  idx;
        get_inputs(d, sel, ena, wr, addr, wdata);
        if (preset) begin
            check1($sformatf("d%0d_rst_PREADY", d), get_ready(d), 1'b0);
            check1($sformatf("d%0d_rst_PSLVERR", d), get_slverr(d), 1'b0);
            check($sformatf("d%0d_rst_PRDATA", d), get_rdata(d), 32'h0);
            check1($sformatf("d%0d_rst_irq", d), get_irq(d), 1'b0);
            m_en[d] = 1'b0; m_auto[d] = 1'b0; m_irqen[d] = 1'b0; m_exp[d] = 1'b0;
            m_load[d] = '0; m_value[d] = '0; m_acc[d] = 0;
            return;
        end
        idx    = addr[4:2];
        bad    = (idx > 3'd3);
        access = sel && ena;
        rdy    = access && (m_acc[d] == ws_of(d));
        case (idx)
            3'd0:    rd_val = {29'd0, m_irqen[d], m_auto[d], m_en[d]};
            3'd1:    rd_val = m_load[d];
            3'd2:    rd_val = m_value[d];
            3'd3:    rd_val = {31'd0, m_exp[d]};
            default: rd_val = '0;
        endcase
        check1($sformatf("d%0d_PREADY", d), get_ready(d), rdy);
        check1($sformatf("d%0d_PSLVERR", d), get_slverr(d), rdy && bad);
        check($sformatf("d%0d_PRDATA", d), get_rdata(d), (rdy && !wr && !bad) ? rd_val : 32'h0);
        check1($sformatf("d%0d_irq", d), get_irq(d), m_exp[d] && m_irqen[d]);

        // Advance to the state after the coming rising edge.
        m_acc[d] = (access && !rdy) ? m_acc[d] + 1 : 0;
        expiry   = m_en[d] && (m_value[d] == 32'd1);
        nval     = m_value[d];
        nen      = m_en[d];
        if (m_en[d] && m_value[d] > 32'd1) nval = m_value[d] - 32'd1;
        if (expiry) begin
            if (m_auto[d]) nval = m_load[d];
            else begin nval = 32'd0; nen = 1'b0; end
        end
        commit = rdy && wr && !bad;
        nexp   = expiry || (m_exp[d] && !(commit && idx == 3'd3 && wdata[0]));
        if (commit && idx == 3'd0) begin
            nen = wdata[0]; m_auto[d] = wdata[1]; m_irqen[d] = wdata[2];
        end
        if (commit && idx == 3'd1) begin
            m_load[d] = wdata; nval = wdata;
        end
        m_en[d] = nen; m_value[d] = nval; m_exp[d] = nexp;
    endtask

    initial begin
        forever begin
            @(negedge pclk);
            for (int d = 0; d < 3; d++) model_cycle(d);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic        se;
        int          w;

        preset = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // An access presented during reset must not complete.
        #2;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        #1;
        check1("rst_access_PREADY", get_ready(0), 1'b0);
        check("rst_access_PRDATA", get_rdata(0), 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;

        // Register dump after reset
        apb_xfer(0, 1'b0, 32'h00, 32'h0, rd, se, w); check("rst_CTRL", rd, 32'h0);
        apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, se, w); check("rst_LOAD", rd, 32'h0);
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, se, w); check("rst_VALUE", rd, 32'h0);
        apb_xfer(0, 1'b0, 32'h0C, 32'h0, rd, se, w); check("rst_STATUS", rd, 32'h0);

        // Zero wait states: LOAD=5 then VALUE reads 5, no stall cycles
        apb_xfer(0, 1'b1, 32'h04, 32'd5, rd, se, w);
        check("ws0_write_waits", 32'(w), 32'd0);
        apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, se, w);
        check("ws0_read_waits", 32'(w), 32'd0);
        check("ws0_VALUE", rd, 32'd5);
        check1("ws0_read_PSLVERR", se, 1'b0);

        // Three wait states: write to LOAD commits only in access cycle 4
        drive(1, 1'b1, 1'b0, 1'b1, 32'h04, 32'hA5);
        @(posedge pclk); #1;
        drive(1, 1'b1, 1'b1, 1'b1, 32'h04, 32'hA5);
        for (int i = 1; i <= 4; i++) begin
            @(posedge pclk); #1;
            check($sformatf("ws3_LOAD_after_access_%0d", i), u_dut_ws3.load_q,
                  (i < 4) ? 32'h0 : 32'hA5);
        end
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        apb_xfer(1, 1'b0, 32'h04, 32'h0, rd, se, w);
        check("ws3_read_waits", 32'(w), 32'd3);
        check("ws3_LOAD", rd, 32'hA5);

        // One-shot expiry: LOAD=3, CTRL=EN|IRQ_EN
        apb_write(0, 32'h04, 32'd3);
        apb_write(0, 32'h00, 32'h5);
        check("os_value_0", u_dut_ws0.value_q, 32'd3);
        @(posedge pclk); #1; check("os_value_1", u_dut_ws0.value_q, 32'd2);
        @(posedge pclk); #1; check("os_value_2", u_dut_ws0.value_q, 32'd1);
        check1("os_irq_before", irq_ws0, 1'b0);
        @(posedge pclk); #1; check("os_value_3", u_dut_ws0.value_q, 32'd0);
        check1("os_exp", u_dut_ws0.exp_q, 1'b1);
        check1("os_irq", irq_ws0, 1'b1);
        check1("os_en_cleared", u_dut_ws0.en_q, 1'b0);
        check("os_model_value", m_value[0], 32'd0);
        check1("os_model_exp", m_exp[0], 1'b1);
        @(posedge pclk); #1; check("os_value_hold", u_dut_ws0.value_q, 32'd0);
        apb_xfer(0, 1'b0, 32'h0C, 32'h0, rd, se, w); check("os_STATUS", rd, 32'h1);
        apb_xfer(0, 1'b0, 32'h00, 32'h0, rd, se, w); check("os_CTRL", rd, 32'h4);

        // CTRL write coinciding with one-shot expiry keeps EN; VALUE=0 then holds
        apb_write(0, 32'h0C, 32'h1);
        apb_write(0, 32'h04, 32'd2);
        apb_write(0, 32'h00, 32'h1);
        apb_write(0, 32'h00, 32'h1);     // completes on the expiry edge
        check1("ctrl_vs_exp_en", u_dut_ws0.en_q, 1'b1);
        check("ctrl_vs_exp_value", u_dut_ws0.value_q, 32'd0);
        check1("ctrl_vs_exp_exp", u_dut_ws0.exp_q, 1'b1);
        @(posedge pclk); #1;
        check("zero_value_hold", u_dut_ws0.value_q, 32'd0);
        apb_write(0, 32'h00, 32'h0);
        apb_write(0, 32'h0C, 32'h1);
        check1("exp_cleared", u_dut_ws0.exp_q, 1'b0);

        // Auto-reload with a STATUS clear landing on the expiry edge
        apb_write(0, 32'h04, 32'd2);
        apb_write(0, 32'h00, 32'h3);
        apb_write(0, 32'h0C, 32'h1);     // completes while VALUE=1
        check1("auto_exp_kept", u_dut_ws0.exp_q, 1'b1);
        check("auto_reload", u_dut_ws0.value_q, 32'd2);
        check1("auto_model_exp", m_exp[0], 1'b1);
        apb_write(0, 32'h00, 32'h0);
        apb_write(0, 32'h0C, 32'h1);

        // Unmapped accesses and ignored writes leave the register file alone
        apb_write(0, 32'h04, 32'h1234_5678);
        apb_write(0, 32'h00, 32'h4);
        apb_write(0, 32'h0C, 32'h1);
        for (int pass = 0; pass < 2; pass++) begin
            apb_xfer(0, 1'b0, 32'h00, 32'h0, rd, se, w);
            check($sformatf("dump%0d_CTRL", pass), rd, 32'h4);
            apb_xfer(0, 1'b0, 32'h04, 32'h0, rd, se, w);
            check($sformatf("dump%0d_LOAD", pass), rd, 32'h1234_5678);
            apb_xfer(0, 1'b0, 32'h08, 32'h0, rd, se, w);
            check($sformatf("dump%0d_VALUE", pass), rd, 32'h1234_5678);
            apb_xfer(0, 1'b0, 32'h0C, 32'h0, rd, se, w);
            check($sformatf("dump%0d_STATUS", pass), rd, 32'h0);
            if (pass == 0) begin
                apb_xfer(0, 1'b1, 32'h14, 32'hFFFF_FFFF, rd, se, w);
                check1("unmapped_wr_PSLVERR", se, 1'b1);
                apb_xfer(0, 1'b0, 32'h14, 32'h0, rd, se, w);
                check1("unmapped_rd_PSLVERR", se, 1'b1);
                check("unmapped_rd_PRDATA", rd, 32'h0);
                apb_xfer(0, 1'b0, 32'h1C, 32'h0, rd, se, w);
                check1("unmapped_1c_PSLVERR", se, 1'b1);
                apb_xfer(0, 1'b1, 32'h08, 32'hDEAD, rd, se, w);
                check1("value_wr_PSLVERR", se, 1'b0);
                apb_xfer(0, 1'b0, 32'hFFFF_FF04, 32'h0, rd, se, w);
                check("alias_LOAD", rd, 32'h1234_5678);
            end
        end

        // Reset in the middle of a CTRL write on the two-wait-state instance
        apb_write(2, 32'h00, 32'h6);
        check("ws2_ctrl_set", 32'({u_dut_ws2.irq_en_q, u_dut_ws2.auto_q, u_dut_ws2.en_q}), 32'h6);
        drive(2, 1'b1, 1'b0, 1'b1, 32'h00, 32'h7);
        @(posedge pclk); #1;
        drive(2, 1'b1, 1'b1, 1'b1, 32'h00, 32'h7);
        @(posedge pclk); #3;             // second access cycle, still stalled
        preset = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'({u_dut_ws2.irq_en_q, u_dut_ws2.auto_q, u_dut_ws2.en_q}), 32'h0);
        check1("rst_mid_PREADY", get_ready(2), 1'b0);
        check1("rst_mid_PSLVERR", get_slverr(2), 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        apb_xfer(2, 1'b1, 32'h04, 32'h77, rd, se, w);
        check("post_rst_write_waits", 32'(w), 32'd2);
        apb_xfer(2, 1'b0, 32'h04, 32'h0, rd, se, w);
        check("post_rst_LOAD", rd, 32'h77);
        apb_xfer(2, 1'b0, 32'h00, 32'h0, rd, se, w);
        check("post_rst_CTRL", rd, 32'h0);

        repeat (3) @(posedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
